cpu_addr_seq: RTL and testbench

Operand-fetch and effective-address sequencer for the next-generation RP2A03 CPU core. It replaces the fixed two-state immediate/implied decode with a parametrised multi-cycle sequencer covering implied, immediate, zero-page (plain and X/Y-indexed) and absolute (plain and X/Y-indexed) modes. It adds bus-ready stalling and optional page-cross penalty cycles. The sequencer sits between the core's decode stage and the memory bus and owns the bus while `busy` is high.

---
 rtl/cpu_addr_seq.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_addr_seq.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_addr_seq.sv
// cpu_addr_seq: operand-fetch and effective-address sequencer for the
// RP2A03 core; owns the memory bus while busy is high.
module cpu_addr_seq #(
  parameter int PAGE_CROSS_PENALTY = 1,
  parameter int ZP_WRAP            = 1
) (
  input  logic        cpuClk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic        isWrite,
  input  logic [15:0] pcIn,
  input  logic [7:0]  xReg,
  input  logic [7:0]  yReg,
  input  logic [7:0]  dataRd,
  input  logic        rdy,
  output logic [15:0] addr,
  output logic        busReq,
  output logic        pcAdv,
  output logic [15:0] pcOut,
  output logic [7:0]  operand,
  output logic [15:0] effAddr,
  output logic        pageCross,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] M_IMP  = 3'd0;
  localparam logic [2:0] M_IMM  = 3'd1;
  localparam logic [2:0] M_ZP   = 3'd2;
  localparam logic [2:0] M_ZPX  = 3'd3;
  localparam logic [2:0] M_ZPY  = 3'd4;
  localparam logic [2:0] M_ABS  = 3'd5;
  localparam logic [2:0] M_ABSX = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_LO,
    S_OP_HI,
    S_FIX,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic        wr_q, wr_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  fix_lo_q, fix_lo_d;
  logic [7:0]  operand_q, operand_d;
  logic [15:0] eff_q, eff_d;
  logic        pcross_q, pcross_d;
  logic        pc_adv_q, pc_adv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        use_x;
  logic        is_zpi;
  logic [7:0]  idx;
  logic [8:0]  zp_sum;
  logic [8:0]  abs_sum;

  always_comb begin
    use_x   = (mode_q == M_ZPX) || (mode_q == M_ABSX);
    is_zpi  = (mode_q == M_ZPX) || (mode_q == M_ZPY);
    idx     = use_x ? x_q : y_q;
    zp_sum  = {1'b0, dataRd} + {1'b0, idx};
    abs_sum = {1'b0, lo_q} + {1'b0, idx};
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wr_d      = wr_q;
    pc_d      = pc_q;
    x_d       = x_q;
    y_d       = y_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    fix_lo_d  = fix_lo_q;
    operand_d = operand_q;
    eff_d     = eff_q;
    pcross_d  = pcross_q;
    pc_adv_d  = 1'b0;
    // a low rdy freezes every piece of sequencing state
    if (rdy) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_d   = mode;
            wr_d     = isWrite;
            pc_d     = pcIn;
            x_d      = xReg;
            y_d      = yReg;
            pcross_d = 1'b0;
            state_d  = (mode == M_IMP) ? S_DONE : S_OP_LO;
          end
        end
        S_OP_LO: begin
          lo_d     = dataRd;
          pc_adv_d = 1'b1;
          pc_d     = pc_q + 16'd1;
          state_d  = S_DONE;
          unique case (1'b1)
            (mode_q == M_IMM): operand_d = dataRd;
            (mode_q == M_ZP):  eff_d = {8'h00, dataRd};
            is_zpi: begin
              if (ZP_WRAP != 0) eff_d = {8'h00, zp_sum[7:0]};
              else              eff_d = {7'b0, zp_sum};
            end
            default: state_d = S_OP_HI;
          endcase
        end
        S_OP_HI: begin
          pc_adv_d = 1'b1;
          pc_d     = pc_q + 16'd1;
          hi_d     = dataRd;
          if (mode_q == M_ABS) begin
            eff_d   = {dataRd, lo_q};
            state_d = S_DONE;
          end else begin
            fix_lo_d = abs_sum[7:0];
            eff_d    = {dataRd + {7'b0, abs_sum[8]}, abs_sum[7:0]};
            pcross_d = abs_sum[8];
            if (wr_q || (abs_sum[8] && (PAGE_CROSS_PENALTY != 0)))
              state_d = S_FIX;
            else
              state_d = S_DONE;
          end
        end
        S_FIX:   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // the FIX read targets the high byte before carry correction
  always_comb begin
    unique case (state_q)
      S_OP_LO, S_OP_HI: begin
        addr   = pc_q;
        busReq = 1'b1;
      end
      S_FIX: begin
        addr   = {hi_q, fix_lo_q};
        busReq = 1'b1;
      end
      default: begin
        addr   = pc_q;
        busReq = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cpuClk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 3'd0;
      wr_q      <= 1'b0;
      pc_q      <= 16'h0000;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      lo_q      <= 8'h00;
      hi_q      <= 8'h00;
      fix_lo_q  <= 8'h00;
      operand_q <= 8'h00;
      eff_q     <= 16'h0000;
      pcross_q  <= 1'b0;
      pc_adv_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wr_q      <= wr_d;
      pc_q      <= pc_d;
      x_q       <= x_d;
      y_q       <= y_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      fix_lo_q  <= fix_lo_d;
      operand_q <= operand_d;
      eff_q     <= eff_d;
      pcross_q  <= pcross_d;
      pc_adv_q  <= pc_adv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pcAdv     = pc_adv_q;
  assign pcOut     = pc_q;
  assign operand   = operand_q;
  assign effAddr   = eff_q;
  assign pageCross = pcross_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cpu_addr_seq.sv
// tb_cpu_addr_seq: scoreboard bench for cpu_addr_seq; a default instance
// and a no-penalty/no-wrap instance share stimulus.
module tb_cpu_addr_seq;

  logic        cpuClk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        isWrite = 1'b0;
  logic [15:0] pcIn = 16'h0000;
  logic [7:0]  xReg = 8'h00;
  logic [7:0]  yReg = 8'h00;
  logic        rdy = 1'b1;

  logic [7:0]  mem [0:65535];

  logic [7:0]  dataRd, dataRd_a;
  logic [15:0] addr, addr_a, pcOut, pcOut_a, effAddr, effAddr_a;
  logic [7:0]  operand, operand_a;
  logic        busReq, busReq_a, pcAdv, pcAdv_a;
  logic        pageCross, pageCross_a, busy, busy_a, done, done_a;

  assign dataRd   = mem[addr];
  assign dataRd_a = mem[addr_a];

  cpu_addr_seq u_dut (
    .cpuClk(cpuClk), .reset(reset), .start(start), .mode(mode),
    .isWrite(isWrite), .pcIn(pcIn), .xReg(xReg), .yReg(yReg),
    .dataRd(dataRd), .rdy(rdy), .addr(addr), .busReq(busReq),
    .pcAdv(pcAdv), .pcOut(pcOut), .operand(operand),
    .effAddr(effAddr), .pageCross(pageCross), .busy(busy),
    .done(done)
  );

  cpu_addr_seq #(.PAGE_CROSS_PENALTY(0), .ZP_WRAP(0)) u_alt (
    .cpuClk(cpuClk), .reset(reset), .start(start), .mode(mode),
    .isWrite(isWrite), .pcIn(pcIn), .xReg(xReg), .yReg(yReg),
    .dataRd(dataRd_a), .rdy(rdy), .addr(addr_a), .busReq(busReq_a),
    .pcAdv(pcAdv_a), .pcOut(pcOut_a), .operand(operand_a),
    .effAddr(effAddr_a), .pageCross(pageCross_a), .busy(busy_a),
    .done(done_a)
  );

  always #5 cpuClk = ~cpuClk;

  typedef struct packed {
    logic [15:0] eff;
    logic [7:0]  opnd;
    logic [15:0] pc;
    logic        pcx;
  } res_t;

  typedef struct {
    res_t m;
    res_t a;
    int   t;
    int   ta;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] stall_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cm, ca, padv, spadv, dcnt;

  function automatic res_t mk(input logic [15:0] eff, input logic [7:0] op,
                              input logic [15:0] pc, input logic pcx);
    res_t r;
    r.eff  = eff;
    r.opnd = op;
    r.pc   = pc;
    r.pcx  = pcx;
    return r;
  endfunction

  function automatic exp_t mke(input res_t m, input res_t a,
                               input int t, input int ta);
    exp_t e;
    e.m  = m;
    e.a  = a;
    e.t  = t;
    e.ta = ta;
    return e;
  endfunction

  task automatic setup(input logic [2:0] md, input logic wr,
                       input logic [15:0] pc, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] b0,
                       input logic [7:0] b1);
    mode    = md;
    isWrite = wr;
    pcIn    = pc;
    xReg    = x;
    yReg    = y;
    mem[pc] = b0;
    mem[pc + 16'd1] = b1;
  endtask

  // start one sequence, apply an optional stall window and an optional
  // stray start, record bus activity until both instances finish
  task automatic run_seq(input int st, input int sl, input int pk);
    cm = 0; ca = 0; padv = 0; spadv = 0; dcnt = 0;
    rd_q.delete();
    stall_q.delete();
    @(negedge cpuClk);
    start = 1'b1;
    @(posedge cpuClk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      rdy = !(c >= st && c < st + sl);
      if (c == pk) begin
        start = 1'b1; mode = 3'd1; pcIn = 16'hBEEF;
        xReg = 8'h77; yReg = 8'h77; isWrite = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (busReq) begin
        if (rdy) rd_q.push_back(addr);
        else     stall_q.push_back(addr);
      end
      if (pcAdv) begin
        padv++;
        if (c > st && c <= st + sl) spadv++;
      end
      if (done) begin
        dcnt++;
        if (cm == 0) cm = c;
      end
      if (done_a && ca == 0) ca = c;
      if (cm != 0 && ca != 0 && c > cm && c > ca) break;
      @(posedge cpuClk);
      #1;
    end
    rdy = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) @(posedge cpuClk);
    @(negedge cpuClk);
    n_total++;
    if ({addr, busReq, pcAdv, pcOut, operand, effAddr, pageCross, busy, done} !== '0)
      $display("FAIL reset_main got %h exp 0",
               {addr, busReq, pcAdv, pcOut, operand, effAddr, pageCross, busy, done});
    else n_pass++;
    n_total++;
    if ({addr_a, busReq_a, pcAdv_a, pcOut_a, operand_a, effAddr_a, pageCross_a, busy_a, done_a} !== '0)
      $display("FAIL reset_alt got %h exp 0",
               {addr_a, busReq_a, pcAdv_a, pcOut_a, operand_a, effAddr_a, pageCross_a, busy_a, done_a});
    else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge cpuClk);
    n_total++;
    if ({busy, done, busReq} !== 3'b000)
      $display("FAIL reset_idle got %b exp 000", {busy, done, busReq});
    else n_pass++;
  endtask

  task automatic test_imm();
    exp_t e;
    setup(3'd1, 1'b0, 16'h0200, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_q.push_back(mke(mk(16'h0000, 8'h5A, 16'h0201, 1'b0),
                        mk(16'h0000, 8'h5A, 16'h0201, 1'b0), 2, 2));
    run_seq(0, 0, 0);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross} !== e.m)
      $display("FAIL imm_result got %h exp %h", {effAddr, operand, pcOut, pageCross}, e.m);
    else n_pass++;
    n_total++;
    if (cm !== e.t) $display("FAIL imm_done_cycle got %0d exp %0d", cm, e.t);
    else n_pass++;
    n_total++;
    if (padv !== 1) $display("FAIL imm_pcadv got %0d exp 1", padv);
    else n_pass++;
    n_total++;
    if (rd_q.size() != 1 || rd_q[0] !== 16'h0200)
      $display("FAIL imm_reads got %0d reads exp 1 at 0200", rd_q.size());
    else n_pass++;
    n_total++;
    if (dcnt !== 1) $display("FAIL imm_done_pulses got %0d exp 1", dcnt);
    else n_pass++;
  endtask

  task automatic test_imp();
    exp_t e;
    setup(3'd0, 1'b0, 16'h0400, 8'h00, 8'h00, 8'hEE, 8'hEE);
    exp_q.push_back(mke(mk(16'h0000, 8'h5A, 16'h0400, 1'b0),
                        mk(16'h0000, 8'h5A, 16'h0400, 1'b0), 1, 1));
    run_seq(0, 0, 0);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross} !== e.m)
      $display("FAIL imp_result got %h exp %h", {effAddr, operand, pcOut, pageCross}, e.m);
    else n_pass++;
    n_total++;
    if (cm !== e.t || ca !== e.ta)
      $display("FAIL imp_done_cycle got %0d/%0d exp %0d", cm, ca, e.t);
    else n_pass++;
    n_total++;
    if (padv !== 0 || rd_q.size() != 0)
      $display("FAIL imp_no_bus got pcadv %0d reads %0d exp 0 0", padv, rd_q.size());
    else n_pass++;
  endtask

  task automatic test_zp();
    logic [2:0]  md [4] = '{3'd2, 3'd3, 3'd4, 3'd4};
    logic [7:0]  ix [4] = '{8'h00, 8'h20, 8'h05, 8'hFF};
    logic [7:0]  bt [4] = '{8'h44, 8'hF0, 8'h10, 8'h02};
    logic [15:0] em [4] = '{16'h0044, 16'h0010, 16'h0015, 16'h0001};
    logic [15:0] ea [4] = '{16'h0044, 16'h0110, 16'h0015, 16'h0101};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      setup(md[i], 1'b0, 16'h0300 + 16'(i * 16), ix[i], ix[i], bt[i], 8'h00);
      exp_q.push_back(mke(mk(em[i], 8'h5A, 16'h0301 + 16'(i * 16), 1'b0),
                          mk(ea[i], 8'h5A, 16'h0301 + 16'(i * 16), 1'b0), 2, 2));
      run_seq(0, 0, 0);
      e = exp_q.pop_front();
      n_total++;
      if ({effAddr, operand, pcOut, pageCross} !== e.m)
        $display("FAIL zp%0d_main got %h exp %h", i, {effAddr, operand, pcOut, pageCross}, e.m);
      else n_pass++;
      n_total++;
      if ({effAddr_a, operand_a, pcOut_a, pageCross_a} !== e.a)
        $display("FAIL zp%0d_alt got %h exp %h", i, {effAddr_a, operand_a, pcOut_a, pageCross_a}, e.a);
      else n_pass++;
      n_total++;
      if (cm !== e.t || ca !== e.ta)
        $display("FAIL zp%0d_done_cycle got %0d/%0d exp %0d", i, cm, ca, e.t);
      else n_pass++;
    end
  endtask

  task automatic test_abs_read();
    exp_t e;
    setup(3'd6, 1'b0, 16'h0610, 8'h02, 8'h00, 8'h10, 8'h40);
    exp_q.push_back(mke(mk(16'h4012, 8'h5A, 16'h0612, 1'b0),
                        mk(16'h4012, 8'h5A, 16'h0612, 1'b0), 3, 3));
    run_seq(0, 0, 0);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross} !== e.m)
      $display("FAIL absx_read_result got %h exp %h", {effAddr, operand, pcOut, pageCross}, e.m);
    else n_pass++;
    n_total++;
    if (cm !== e.t || ca !== e.ta)
      $display("FAIL absx_read_cycle got %0d/%0d exp %0d", cm, ca, e.t);
    else n_pass++;
    n_total++;
    if (rd_q.size() != 2 || padv !== 2)
      $display("FAIL absx_read_bus got reads %0d pcadv %0d exp 2 2", rd_q.size(), padv);
    else n_pass++;
  endtask

  task automatic test_absx_store();
    exp_t e;
    setup(3'd6, 1'b1, 16'h0600, 8'h01, 8'h00, 8'h00, 8'h30);
    exp_q.push_back(mke(mk(16'h3001, 8'h5A, 16'h0602, 1'b0),
                        mk(16'h3001, 8'h5A, 16'h0602, 1'b0), 4, 4));
    run_seq(0, 0, 0);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross} !== e.m)
      $display("FAIL store_result got %h exp %h", {effAddr, operand, pcOut, pageCross}, e.m);
    else n_pass++;
    n_total++;
    if (cm !== e.t || ca !== e.ta)
      $display("FAIL store_done_cycle got %0d/%0d exp %0d", cm, ca, e.t);
    else n_pass++;
    n_total++;
    if (rd_q.size() != 3 || rd_q[rd_q.size() - 1] !== 16'h3001)
      $display("FAIL store_fix_read got %0d reads exp 3 ending 3001", rd_q.size());
    else n_pass++;
  endtask

  task automatic test_page_cross();
    exp_t e;
    setup(3'd7, 1'b0, 16'h0500, 8'h00, 8'h10, 8'hF8, 8'h12);
    exp_q.push_back(mke(mk(16'h1308, 8'h5A, 16'h0502, 1'b1),
                        mk(16'h1308, 8'h5A, 16'h0502, 1'b1), 4, 3));
    run_seq(0, 0, 0);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross} !== e.m)
      $display("FAIL absy_cross_main got %h exp %h", {effAddr, operand, pcOut, pageCross}, e.m);
    else n_pass++;
    n_total++;
    if ({effAddr_a, operand_a, pcOut_a, pageCross_a} !== e.a)
      $display("FAIL absy_cross_alt got %h exp %h", {effAddr_a, operand_a, pcOut_a, pageCross_a}, e.a);
    else n_pass++;
    n_total++;
    if (cm !== e.t || ca !== e.ta)
      $display("FAIL absy_cross_cycle got %0d/%0d exp %0d/%0d", cm, ca, e.t, e.ta);
    else n_pass++;
    n_total++;
    if (rd_q.size() != 3 || rd_q[rd_q.size() - 1] !== 16'h1208)
      $display("FAIL absy_fix_addr got %0d reads exp 3 ending 1208", rd_q.size());
    else n_pass++;
    // high byte wraps: FF:F0 + 20 -> 0010
    setup(3'd6, 1'b0, 16'h0510, 8'h20, 8'h00, 8'hF0, 8'hFF);
    exp_q.push_back(mke(mk(16'h0010, 8'h5A, 16'h0512, 1'b1),
                        mk(16'h0010, 8'h5A, 16'h0512, 1'b1), 4, 3));
    run_seq(0, 0, 0);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross} !== e.m)
      $display("FAIL hi_wrap_main got %h exp %h", {effAddr, operand, pcOut, pageCross}, e.m);
    else n_pass++;
    n_total++;
    if ({effAddr_a, operand_a, pcOut_a, pageCross_a} !== e.a)
      $display("FAIL hi_wrap_alt got %h exp %h", {effAddr_a, operand_a, pcOut_a, pageCross_a}, e.a);
    else n_pass++;
    n_total++;
    if (cm !== e.t || ca !== e.ta || rd_q.size() != 3 || rd_q[rd_q.size() - 1] !== 16'hFF10)
      $display("FAIL hi_wrap_timing got %0d/%0d reads %0d exp %0d/%0d ending FF10",
               cm, ca, rd_q.size(), e.t, e.ta);
    else n_pass++;
  endtask

  task automatic test_stall();
    exp_t e;
    setup(3'd5, 1'b0, 16'h0700, 8'h00, 8'h00, 8'h34, 8'h12);
    exp_q.push_back(mke(mk(16'h1234, 8'h5A, 16'h0702, 1'b0),
                        mk(16'h1234, 8'h5A, 16'h0702, 1'b0), 6, 6));
    run_seq(2, 3, 0);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross} !== e.m)
      $display("FAIL stall_result got %h exp %h", {effAddr, operand, pcOut, pageCross}, e.m);
    else n_pass++;
    n_total++;
    if (cm !== e.t || ca !== e.ta)
      $display("FAIL stall_done_cycle got %0d/%0d exp %0d", cm, ca, e.t);
    else n_pass++;
    n_total++;
    if (stall_q.size() != 3 || stall_q[0] !== 16'h0701 || stall_q[2] !== 16'h0701)
      $display("FAIL stall_addr_held got %0d stalled reads exp 3 at 0701", stall_q.size());
    else n_pass++;
    n_total++;
    if (spadv !== 0 || padv !== 2)
      $display("FAIL stall_pcadv got %0d in stall %0d total exp 0 2", spadv, padv);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    setup(3'd5, 1'b0, 16'h0800, 8'h00, 8'h00, 8'hCD, 8'hAB);
    exp_q.push_back(mke(mk(16'hABCD, 8'h5A, 16'h0802, 1'b0),
                        mk(16'hABCD, 8'h5A, 16'h0802, 1'b0), 3, 3));
    run_seq(0, 0, 1);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross, cm} !== {e.m, e.t})
      $display("FAIL busy_start_ignored got %h cyc %0d exp %h cyc %0d",
               {effAddr, operand, pcOut, pageCross}, cm, e.m, e.t);
    else n_pass++;
    setup(3'd5, 1'b0, 16'h0810, 8'h00, 8'h00, 8'h11, 8'h22);
    exp_q.push_back(mke(mk(16'h2211, 8'h5A, 16'h0812, 1'b0),
                        mk(16'h2211, 8'h5A, 16'h0812, 1'b0), 3, 3));
    run_seq(0, 0, 3);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross, cm} !== {e.m, e.t})
      $display("FAIL back_to_back got %h cyc %0d exp %h cyc %0d",
               {effAddr, operand, pcOut, pageCross}, cm, e.m, e.t);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || dcnt !== 1)
      $display("FAIL done_start_ignored got busy %b pulses %0d exp 0 1", busy, dcnt);
    else n_pass++;
  endtask

  task automatic test_abort();
    exp_t e;
    int   dn;
    dn = 0;
    setup(3'd5, 1'b0, 16'h0900, 8'h00, 8'h00, 8'h55, 8'h66);
    @(negedge cpuClk);
    start = 1'b1;
    @(posedge cpuClk);
    #1 start = 1'b0;
    @(posedge cpuClk);
    #1;
    n_total++;
    if ({busReq, addr} !== {1'b1, 16'h0901})
      $display("FAIL abort_in_op_hi got %h exp 10901", {busReq, addr});
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({addr, busReq, pcAdv, pcOut, operand, effAddr, pageCross, busy, done} !== '0)
      $display("FAIL abort_main got %h exp 0",
               {addr, busReq, pcAdv, pcOut, operand, effAddr, pageCross, busy, done});
    else n_pass++;
    n_total++;
    if ({addr_a, busReq_a, pcAdv_a, pcOut_a, operand_a, effAddr_a, pageCross_a, busy_a, done_a} !== '0)
      $display("FAIL abort_alt got %h exp 0",
               {addr_a, busReq_a, pcAdv_a, pcOut_a, operand_a, effAddr_a, pageCross_a, busy_a, done_a});
    else n_pass++;
    repeat (2) begin
      @(posedge cpuClk);
      #1 if (done || done_a) dn++;
    end
    @(negedge cpuClk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge cpuClk);
      #1 if (done || done_a) dn++;
    end
    n_total++;
    if (dn !== 0 || busy !== 1'b0)
      $display("FAIL abort_no_done got %0d pulses busy %b exp 0 0", dn, busy);
    else n_pass++;
    setup(3'd1, 1'b0, 16'h0A00, 8'h00, 8'h00, 8'h3C, 8'h00);
    exp_q.push_back(mke(mk(16'h0000, 8'h3C, 16'h0A01, 1'b0),
                        mk(16'h0000, 8'h3C, 16'h0A01, 1'b0), 2, 2));
    run_seq(0, 0, 0);
    e = exp_q.pop_front();
    n_total++;
    if ({effAddr, operand, pcOut, pageCross, cm} !== {e.m, e.t})
      $display("FAIL after_abort got %h cyc %0d exp %h cyc %0d",
               {effAddr, operand, pcOut, pageCross}, cm, e.m, e.t);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_imm();
    test_imp();
    test_zp();
    test_abs_read();
    test_absx_store();
    test_page_cross();
    test_stall();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
